mem_burst_responder: RTL

//   Main-memory responder serving I-cache and D-cache fill/write-through traffic.
//   - Single request port; reads and writes are never issued in the same cycle.
//   - Writes complete in 1 cycle. Reads return after a fixed 4-cycle latency.
//   - Pipelined: a new read may be issued every cycle, so an 8-beat block fill streams out back-to-back.
//   - Word-wide (16b) storage array, byte-addressed.

---
 rtl/mem_burst_responder.sv | 102 ++++++++++
 1 files changed

// File: rtl/mem_burst_responder.sv
// Pipelined word-wide memory responder: 1-cycle writes, fixed-latency in-order reads.
// Optional beat counter / burst-done strobe enabled by defining MEM_BURST_CNT_EN.
module mem_burst_responder #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_WORDS = 4096,
  parameter int RD_LAT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [2:0]        rd_pending
`ifdef MEM_BURST_CNT_EN
  ,
  output logic [2:0]        beat_cnt,
  output logic              burst_done
`endif
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [ADDR_W-2:0] word_mod;
  logic [IDX_W-1:0]  idx;
  logic              rd_issue;
  logic              wr_issue;

  logic [RD_LAT-1:0] pipe_v;
  logic [DATA_W-1:0] pipe_d [RD_LAT];
  logic [ADDR_W-1:0] pipe_a [RD_LAT];

  assign word_mod = addr[ADDR_W-1:1] % (ADDR_W-1)'(MEM_WORDS);
  assign idx      = word_mod[IDX_W-1:0];
  assign rd_issue = enable && !wr;
  assign wr_issue = enable && wr;

  // Storage survives reset; only the request in the reset cycle is blocked.
  always_ff @(posedge clk) begin
    if (rst && wr_issue)
      mem[idx] <= data_in;
  end

  // Requests are accepted unconditionally (enable is the only valid, no ready);
  // every read yields exactly one data_valid beat and the requester must take it.
  // Data regs only load on a valid slot, so the last stage holds across bubbles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_d[i] <= '0;
        pipe_a[i] <= '0;
      end
    end else begin
      pipe_v[0] <= rd_issue;
      if (rd_issue) begin
        pipe_d[0] <= mem[idx];
        pipe_a[0] <= {addr[ADDR_W-1:1], 1'b0};
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) begin
          pipe_d[i] <= pipe_d[i-1];
          pipe_a[i] <= pipe_a[i-1];
        end
      end
    end
  end

  assign data_valid = pipe_v[RD_LAT-1];
  assign data_out   = pipe_d[RD_LAT-1];
  assign resp_addr  = pipe_a[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_pending <= '0;
    end else if (rd_issue && !data_valid) begin
      if (rd_pending != 3'(RD_LAT))
        rd_pending <= rd_pending + 3'd1;
    end else if (!rd_issue && data_valid) begin
      if (rd_pending != 3'd0)
        rd_pending <= rd_pending - 3'd1;
    end
  end

`ifdef MEM_BURST_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)
      beat_cnt <= '0;
    else if (data_valid)
      beat_cnt <= beat_cnt + 3'd1;
  end

  assign burst_done = data_valid && (beat_cnt == 3'd7);
`endif

endmodule
